regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 XLEN, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 NREGS, default 32: register count; SHALL be a power of two, at least 2; AW = clog2(NREGS).
REQ-003 NRD, default 2: number of read ports, 1 to 4.
REQ-004 BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 returns the stored value only.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rs  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW].
REQ-008 src  out  NRD*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
REQ-009 src_busy  out  NRD  scoreboard busy bit for each read address.
REQ-010 we0, we1  in  1 each  write-port enables.
REQ-011 rd0, rd1  in  AW each  write addresses.
REQ-012 wd0, wd1  in  XLEN each  write data.
REQ-013 be0, be1  in  XLEN/8 each  byte enables; bit k covers byte k.
REQ-014 iss_valid  in  1  issue strobe; marks iss_rd as awaiting a write.
REQ-015 iss_rd  in  AW  destination being issued.
REQ-016 busy_cnt  out  AW+1  count of busy registers.

Function
REQ-017 Register 0 SHALL always read as 0, never be written, and never be busy.
REQ-018 A write SHALL commit at the rising edge when weN=1 and rdN!=0, updating only bytes whose beN bit is 1.
REQ-019 A write with beN all-zero SHALL leave the data unchanged and SHALL still clear busy for rdN.
REQ-020 If we0 and we1 both target the same nonzero rd, the bytes enabled in be1 SHALL take wd1; bytes enabled only in be0 SHALL take wd0.
REQ-021 Reads SHALL be combinational from rs and the current register contents.
REQ-022 With BYPASS=1, a read whose address matches an active nonzero write in the same cycle SHALL return the post-edge merged value, using the rules in REQ-018 and REQ-020.
REQ-023 With BYPASS=0, a read SHALL return the pre-edge value.
REQ-024 The busy bit for r SHALL be set at the edge when iss_valid=1 and iss_rd=r!=0.
REQ-025 The busy bit SHALL be cleared at the edge when any write port has weN=1 and rdN=r.
REQ-026 If a set and a clear hit the same register in the same cycle, the set SHALL win, because the new producer supersedes the old one.
REQ-027 src_busy[p] SHALL reflect the registered busy bit for rs[p].
REQ-028 With BYPASS=1, src_busy[p] SHALL read 0 when a same-cycle write clears that register and no same-cycle issue sets it.
REQ-029 busy_cnt SHALL equal the number of set busy bits, registered and updated in the same edge as those bits.
REQ-030 busy_cnt SHALL never exceed NREGS-1.
REQ-031 Issuing a register that is already busy SHALL keep it busy and SHALL leave busy_cnt unchanged.

Reset
REQ-032 While rst=1 at an edge, all registers SHALL be cleared to 0, all busy bits cleared, and busy_cnt set to 0.
REQ-033 rst SHALL override all writes and issues in the same cycle.
REQ-034 The first edge after rst deasserts SHALL accept writes and issues normally.
REQ-035 Reset asserted mid-operation SHALL discard all pending busy state.

Verification
REQ-036 Reset, then read all addresses on every port -> every src value = 0, src_busy = 0, busy_cnt = 0.
REQ-037 Write x1=0xDEADBEEF with be0=0xF, then write x1=0x11223344 with be0=0x5 -> x1 = 0xDE22BE44.
REQ-038 Same cycle we0 to x5 with 0xAAAAAAAA/be 0xF and we1 to x5 with 0x55555555/be 0x3, rs[0]=5, BYPASS=1 -> src0 = 0xAAAA5555 combinationally and after the edge; with BYPASS=0 -> src0 holds the old value until the edge.
REQ-039 Issue x7, then x9 (busy_cnt=2), then in one cycle write x7 and issue x7 -> x7 stays busy, busy_cnt=2; then write x9 -> busy_cnt=1.
REQ-040 Write x0=0xFFFFFFFF and issue x0 -> x0 reads 0, src_busy=0, busy_cnt unchanged.
REQ-041 Issue x3 and write x4=0x1234, then assert rst together with we1 to x4=0x5678 -> after the edge, x4 = 0, busy_cnt = 0, and x3 is not busy.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-read, dual-write register file with a per-register
// busy scoreboard for tracking in-flight producers.
//
// Parameters:
//   XLEN   data width in bits (multiple of 8)
//   NREGS  register count (power of two, >= 2); AW = clog2(NREGS)
//   NRD    number of read ports (1..4)
//   BYPASS 1: reads see same-cycle writes; 0: reads see stored value only
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rs / src / src_busy   NRD packed read ports (address, data, busy bit)
//   we0/rd0/wd0/be0       write port 0 (enable, address, data, byte enables)
//   we1/rd1/wd1/be1       write port 1; wins per byte over port 0
//   iss_valid / iss_rd    issue strobe marking iss_rd busy
//   busy_cnt              registered count of busy registers
//
// Register 0 is hardwired to zero and can never be busy.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS),
  localparam int NB    = XLEN / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] src,
  output logic [NRD-1:0]      src_busy,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       rd0,
  input  logic [AW-1:0]       rd1,
  input  logic [XLEN-1:0]     wd0,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NB-1:0]       be0,
  input  logic [NB-1:0]       be1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clr_vec, set_vec;
  logic [AW:0]      cnt_q, cnt_d;

  // Post-edge value of one register: port 0 bytes first, then port 1 bytes
  // on top so port 1 wins wherever both enable the same byte.
  function automatic logic [XLEN-1:0] merge_wr(input logic [XLEN-1:0] old,
                                               input logic [AW-1:0]   a);
    logic [XLEN-1:0] v;
    v = old;
    for (int k = 0; k < NB; k++) begin
      if (we0 && rd0 == a && be0[k]) v[k*8 +: 8] = wd0[k*8 +: 8];
      if (we1 && rd1 == a && be1[k]) v[k*8 +: 8] = wd1[k*8 +: 8];
    end
    return v;
  endfunction

  // Next-state data and busy scoreboard.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    regs_d[0] = '0;
    clr_vec   = '0;
    set_vec   = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i]  = merge_wr(regs_q[i], AW'(i));
      // An all-zero byte enable still counts as a write for busy clearing.
      clr_vec[i] = (we0 && rd0 == AW'(i)) || (we1 && rd1 == AW'(i));
      set_vec[i] = iss_valid && iss_rd == AW'(i);
    end
    // A new issue supersedes the producer that is writing back now.
    busy_d = (busy_q & ~clr_vec) | set_vec;
    cnt_d  = '0;
    for (int i = 0; i < NREGS; i++) cnt_d = cnt_d + (AW+1)'(busy_d[i]);
  end

  // Read ports.
  always_comb begin
    logic [AW-1:0] a;
    src      = '0;
    src_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      a = rs[p*AW +: AW];
      if (a != '0) src[p*XLEN +: XLEN] = (BYPASS != 0) ? regs_d[a] : regs_q[a];
      // With bypass, a register being written back this cycle already looks
      // free unless a fresh issue re-claims it in the same cycle.
      if (BYPASS != 0) src_busy[p] = busy_q[a] & ~(clr_vec[a] & ~set_vec[a]);
      else             src_busy[p] = busy_q[a];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the storage array is reset here because contents must read as
      // zero after reset; a plain RAM without that need would skip this.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule
